// File: rtl/vpu_seq.sv
// Vector command sequencer: walks a multi-element VPU command, issuing one start per element
// and advancing the operand addresses, with abort support and a completion pulse.
module vpu_seq #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned OP_W   = 10,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  input  logic [ADDR_W-1:0] cmd_addr_const,
  input  logic              abort,
  output logic              vpu_start,
  input  logic              vpu_done,
  output logic [OP_W-1:0]   vpu_opcode,
  output logic [ADDR_W-1:0] vpu_addr_a,
  output logic [ADDR_W-1:0] vpu_addr_b,
  output logic [ADDR_W-1:0] vpu_addr_c,
  output logic [ADDR_W-1:0] vpu_addr_const,
  output logic              busy,
  output logic              cmd_done,
  output logic              aborted,
  output logic [LEN_W-1:0]  elem_idx
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  state_e              state_q;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   a_q, b_q, c_q, k_q;
  logic [LEN_W-1:0]    len_q, idx_q;
  logic                const_mode_q, abort_pend_q, cmd_done_q, aborted_q;
  logic                last_elem;

  assign cmd_ready      = (state_q == StIdle);
  assign busy           = ~cmd_ready;
  // An abort seen in the issue cycle suppresses the start outright.
  assign vpu_start      = (state_q == StIssue) && !abort;
  assign vpu_opcode     = op_q;
  assign vpu_addr_a     = a_q;
  assign vpu_addr_b     = b_q;
  assign vpu_addr_c     = c_q;
  assign vpu_addr_const = k_q;
  assign cmd_done       = cmd_done_q;
  assign aborted        = aborted_q;
  assign elem_idx       = idx_q;
  assign last_elem      = ((idx_q + LEN_W'(1)) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      const_mode_q <= 1'b0;
      abort_pend_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q         <= cmd_opcode;
            a_q          <= cmd_addr_a;
            b_q          <= cmd_addr_b;
            c_q          <= cmd_addr_c;
            k_q          <= cmd_addr_const;
            len_q        <= cmd_len;
            idx_q        <= '0;
            const_mode_q <= (cmd_addr_b == '0) && (cmd_addr_const != '0);
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            state_q      <= (cmd_len == '0) ? StFinish : StIssue;
          end
        end
        StIssue: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= StFinish;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (abort) abort_pend_q <= 1'b1;
          if (vpu_done) begin
            if (last_elem || abort_pend_q || abort) begin
              aborted_q <= abort_pend_q || abort;
              state_q   <= StFinish;
            end else begin
              idx_q   <= idx_q + LEN_W'(1);
              a_q     <= a_q + ADDR_W'(1);
              c_q     <= c_q + ADDR_W'(1);
              if (!const_mode_q) b_q <= b_q + ADDR_W'(1);
              state_q <= StIssue;
            end
          end
        end
        StFinish: begin
          cmd_done_q   <= 1'b1;
          abort_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
